// File: rtl/aes_resp_monitor_pkg.sv
// Shared types and constants for the AES response monitor: FSM states,
// MISR feedback taps and default parameter values.
package aes_resp_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        COMPACT = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Zero-based bit indices of the x^128 + x^126 + x^101 + x^99 feedback taps
    localparam int MISR_TAP_A = 127;
    localparam int MISR_TAP_B = 125;
    localparam int MISR_TAP_C = 100;
    localparam int MISR_TAP_D = 98;

    localparam int           DEFAULT_LATENCY  = 21;
    localparam logic [127:0] DEFAULT_SIG_SEED = 128'hFACE_0FF0_FACE_0FF0_FACE_0FF0_FACE_0FF0;

endpackage

// File: rtl/aes_misr.sv
// Multiple-input signature register: shifts left with LFSR feedback in bit 0
// and folds in one data word per enabled cycle.
module aes_misr
    import aes_resp_monitor_pkg::*;
#(
    parameter int                   NUM_BITS  = 128,
    parameter logic [NUM_BITS-1:0]  RESET_SIG = DEFAULT_SIG_SEED
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [NUM_BITS-1:0] seed,
    input  logic                en,
    input  logic [NUM_BITS-1:0] data,
    output logic [NUM_BITS-1:0] sig
);

    logic fb;

    assign fb = sig[MISR_TAP_A] ^ sig[MISR_TAP_B] ^ sig[MISR_TAP_C] ^ sig[MISR_TAP_D];

    // load wins over en so a restart always begins from a clean seed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= RESET_SIG;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= {sig[NUM_BITS-2:0], fb} ^ data;
        end
    end

endmodule

// File: rtl/aes_resp_monitor.sv
// Compacts a run of AES ciphertext responses into a MISR signature, timing
// each response by a valid pipe that mirrors the core's launch-to-output latency.
module aes_resp_monitor
    import aes_resp_monitor_pkg::*;
#(
    parameter int                  NUM_BITS = 128,
    parameter int                  LATENCY  = DEFAULT_LATENCY,
    parameter logic [NUM_BITS-1:0] SIG_SEED = DEFAULT_SIG_SEED
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [31:0]         i_num_tests,
    input  logic                i_launch,
    input  logic [NUM_BITS-1:0] i_data,
    input  logic [NUM_BITS-1:0] i_golden,
    output logic [NUM_BITS-1:0] o_signature,
    output logic [31:0]         o_count,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass
);

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    state_e               state;
    logic [31:0]          total_q;
    logic [31:0]          count_q;
    logic [LATENCY-1:0]   vpipe;
    logic                 busy_q;
    logic                 done_q;
    logic                 v_out;
    logic                 start_fire;
    logic                 update_en;

    assign v_out      = vpipe[LATENCY-1];
    assign start_fire = ((state == IDLE) || (state == DONE)) && i_start;
    // Responses arriving after the run total is reached are dropped
    assign update_en  = v_out && ((state == FILL) ||
                                  ((state == COMPACT) && (count_q < total_q)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            total_q <= 32'd0;
            count_q <= 32'd0;
            vpipe   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        total_q <= i_num_tests;
                        count_q <= 32'd0;
                        vpipe   <= '0;
                        if (i_num_tests == 32'd0) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state  <= FILL;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    vpipe <= {vpipe[LATENCY-2:0], i_launch};
                    if (v_out) begin
                        state   <= COMPACT;
                        count_q <= (count_q == COUNT_MAX) ? count_q : count_q + 32'd1;
                    end
                end
                COMPACT: begin
                    vpipe <= {vpipe[LATENCY-2:0], i_launch};
                    if (count_q >= total_q) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (v_out) begin
                        count_q <= (count_q == COUNT_MAX) ? count_q : count_q + 32'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    aes_misr #(
        .NUM_BITS  (NUM_BITS),
        .RESET_SIG (SIG_SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (start_fire),
        .seed (SIG_SEED),
        .en   (update_en),
        .data (i_data),
        .sig  (o_signature)
    );

    assign o_count = count_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_pass  = (state == DONE) && (o_signature == i_golden);

endmodule

// File: tb/tb_aes_resp_monitor.sv
// Bench for aes_resp_monitor: a default-seed instance for randomized runs and a
// zero-seed instance for the hand-computed signature vector.
module tb_aes_resp_monitor;

    localparam int           LAT  = 21;
    localparam logic [127:0] SEED = 128'hFACE_0FF0_FACE_0FF0_FACE_0FF0_FACE_0FF0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [31:0]  num_tests = 32'd0;
    logic         launch = 1'b0;
    logic [127:0] data = '0;
    logic [127:0] golden = '0;

    logic [127:0] sig, z_sig;
    logic [31:0]  count, z_count;
    logic         busy, done, pass;
    logic         z_busy, z_done, z_pass;

    int tests_run = 0;
    int fails = 0;

    aes_resp_monitor dut (
        .clk(clk), .rst(rst), .i_start(start), .i_num_tests(num_tests),
        .i_launch(launch), .i_data(data), .i_golden(golden),
        .o_signature(sig), .o_count(count), .o_busy(busy), .o_done(done), .o_pass(pass)
    );

    aes_resp_monitor #(.SIG_SEED(128'h0)) dut_z (
        .clk(clk), .rst(rst), .i_start(start), .i_num_tests(num_tests),
        .i_launch(launch), .i_data(data), .i_golden(golden),
        .o_signature(z_sig), .o_count(z_count), .o_busy(z_busy), .o_done(z_done), .o_pass(z_pass)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] misr_next(input logic [127:0] s, input logic [127:0] d);
        logic fb;
        fb = s[127] ^ s[125] ^ s[100] ^ s[98];
        return {s[126:0], fb} ^ d;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        tests_run++; if (sig !== SEED) begin fails++; $display("FAIL reset_sig got %h exp %h", sig, SEED); end
        tests_run++; if (count !== 32'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
        tests_run++; if ({busy, done, pass} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {busy, done, pass}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_zero_tests();
        golden = SEED;
        num_tests = 32'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        tests_run++; if ({busy, done} !== 2'b01) begin fails++; $display("FAIL zero_flags got %b exp 01", {busy, done}); end
        tests_run++; if (sig !== SEED) begin fails++; $display("FAIL zero_sig got %h exp %h", sig, SEED); end
        tests_run++; if (count !== 32'd0) begin fails++; $display("FAIL zero_count got %0d exp 0", count); end
        tests_run++; if (pass !== 1'b1) begin fails++; $display("FAIL zero_pass got %b exp 1", pass); end
    endtask

    // Two launches of data 1 into the zero-seed instance: signature 1 then 3
    task automatic test_vector();
        num_tests = 32'd2;
        data = 128'h1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c <= 23; c++) begin
            launch = (c <= 1);
            step();
            if (c <= 20) begin
                tests_run++; if (z_count !== 32'd0 || z_sig !== 128'h0) begin
                    fails++; $display("FAIL vec_hold edge %0d got sig %h count %0d exp 0/0", c, z_sig, z_count);
                end
            end else if (c == 21) begin
                tests_run++; if (z_sig !== 128'h1 || z_count !== 32'd1) begin
                    fails++; $display("FAIL vec_first got sig %h count %0d exp 1/1", z_sig, z_count);
                end
            end else if (c == 22) begin
                tests_run++; if (z_sig !== 128'h3 || z_count !== 32'd2 || z_done !== 1'b0) begin
                    fails++; $display("FAIL vec_second got sig %h count %0d done %b exp 3/2/0", z_sig, z_count, z_done);
                end
            end else begin
                tests_run++; if (z_done !== 1'b1 || z_busy !== 1'b0 || z_sig !== 128'h3) begin
                    fails++; $display("FAIL vec_done got done %b busy %b sig %h exp 1/0/3", z_done, z_busy, z_sig);
                end
            end
        end
        launch = 1'b0;
    endtask

    // Generic scoreboarded run on the default instance; pulse_edge >= 0 pulses
    // start (with a different total) at that edge while the run is busy.
    task automatic run_model(input int n, input int n_launch, input int gap_pct,
                             input int pulse_edge, output logic [127:0] fin);
        logic [127:0] msig;
        logic [127:0] exp_sig;
        logic [127:0] exp_q[$];
        int           due_q[$];
        int           mcount;
        int           made;
        int           done_edge;
        bit           finished;
        num_tests = n;
        golden = SEED;
        launch = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        tests_run++; if (busy !== 1'b1 || done !== 1'b0 || count !== 32'd0 || sig !== SEED) begin
            fails++; $display("FAIL run_start got busy %b done %b count %0d sig %h", busy, done, count, sig);
        end
        msig = SEED; mcount = 0; made = 0; done_edge = -1; finished = 0;
        for (int c = 0; c < 600 && !finished; c++) begin
            launch = (made < n_launch) && ($urandom_range(0, 99) >= gap_pct);
            if (launch) begin
                made++;
                due_q.push_back(c + LAT);
            end
            data = rand128();
            start = (c == pulse_edge);
            num_tests = (c == pulse_edge) ? 32'd1 : n;
            if (due_q.size() > 0 && due_q[0] == c) begin
                void'(due_q.pop_front());
                if (mcount < n) begin
                    msig = misr_next(msig, data);
                    mcount++;
                    if (mcount == n) done_edge = c + 1;
                end
            end
            exp_q.push_back(msig);
            step();
            exp_sig = exp_q.pop_front();
            tests_run++; if (sig !== exp_sig || count !== mcount) begin
                fails++; $display("FAIL run_sig edge %0d got %h/%0d exp %h/%0d", c, sig, count, exp_sig, mcount);
            end
            if (c == 0) begin
                tests_run++; if (pass !== 1'b0) begin fails++; $display("FAIL pass_gated got %b exp 0", pass); end
            end
            if (c == done_edge) begin
                finished = 1;
                tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin
                    fails++; $display("FAIL run_done got done %b busy %b exp 1/0", done, busy);
                end
            end else begin
                tests_run++; if (done !== 1'b0 || busy !== 1'b1) begin
                    fails++; $display("FAIL run_busy edge %0d got done %b busy %b exp 0/1", c, done, busy);
                end
            end
        end
        if (!finished) begin
            tests_run++; fails++;
            $display("FAIL run_timeout got no done exp done after %0d responses", n);
        end
        launch = 1'b0;
        start = 1'b0;
        fin = msig;
    endtask

    task automatic test_random();
        logic [127:0] fin;
        run_model(6, 8, 50, -1, fin);
        run_model(3, 3, 20, -1, fin);
    endtask

    task automatic test_start_ignored();
        logic [127:0] fin;
        run_model(3, 5, 0, 22, fin);
    endtask

    task automatic test_pass();
        logic [127:0] fin;
        run_model(4, 4, 30, -1, fin);
        golden = fin;
        #1;
        tests_run++; if (pass !== 1'b1) begin fails++; $display("FAIL pass_match got %b exp 1", pass); end
        golden = fin ^ (128'h1 << $urandom_range(0, 127));
        #1;
        tests_run++; if (pass !== 1'b0) begin fails++; $display("FAIL pass_flip got %b exp 0", pass); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] fin;
        golden = SEED;
        num_tests = 32'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        launch = 1'b1;
        for (int c = 0; c < 10; c++) begin
            data = rand128();
            step();
        end
        #1;
        rst = 1'b1;
        #1;
        tests_run++; if ({busy, done, pass} !== 3'b000 || count !== 32'd0 || sig !== SEED) begin
            fails++; $display("FAIL rst_mid got flags %b count %0d sig %h", {busy, done, pass}, count, sig);
        end
        launch = 1'b0;
        step();
        rst = 1'b0;
        step();
        tests_run++; if ({busy, done, pass} !== 3'b000) begin
            fails++; $display("FAIL rst_idle got flags %b exp 000", {busy, done, pass});
        end
        run_model(4, 4, 30, -1, fin);
    endtask

    initial begin
        test_reset();
        test_zero_tests();
        test_vector();
        test_random();
        test_start_ignored();
        test_pass();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
